// File: rtl/csr_trap_ctrl.sv
// Trap/CSR control stage: executes CSRRW/CSRRS/CSRRC, ECALL and MRET.
// It drives per-CSR write pulses to the machine-mode CSR file and returns a registered response.
module csr_trap_ctrl #(
  parameter logic [31:0] ECALL_CAUSE = 32'd11,
  parameter logic [31:0] MSTATUS_RST = 32'h00001800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [11:0] req_csr_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  input  logic [31:0] csr_mstatus,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  input  logic [31:0] csr_mcause,
  input  logic [31:0] csr_mvendorid,
  input  logic [31:0] csr_marchid,
  output logic [31:0] din_mstatus,
  output logic [31:0] din_mtvec,
  output logic [31:0] din_mepc,
  output logic [31:0] din_mcause,
  output logic        wen_mstatus,
  output logic        wen_mtvec,
  output logic        wen_mepc,
  output logic        wen_mcause,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_redirect,
  output logic [31:0] resp_npc,
  output logic        resp_illegal
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [2:0] OP_CSRRW = 3'd0;
  localparam logic [2:0] OP_CSRRS = 3'd1;
  localparam logic [2:0] OP_CSRRC = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_MRET  = 3'd4;

  state_t      state_reg, state_next;
  logic [2:0]  op_reg;
  logic [11:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] pc_reg;

  // sel bit order: mstatus, mtvec, mepc, mcause, mvendorid, marchid
  logic [5:0]  sel;
  logic [31:0] old_val;
  logic [31:0] new_val;
  logic        is_csr_op;
  logic        wr_req;
  logic        illegal;
  logic        do_write;
  logic [31:0] ecall_mstatus;
  logic [31:0] mret_mstatus;
  logic [31:0] rdata_next;
  logic        redirect_next;
  logic [31:0] npc_next;

  // Decode of the latched request against the current CSR values
  always_comb begin
    sel = 6'b0;
    old_val = 32'd0;
    case (addr_reg)
      12'h300: begin sel[0] = 1'b1; old_val = csr_mstatus;   end
      12'h305: begin sel[1] = 1'b1; old_val = csr_mtvec;     end
      12'h341: begin sel[2] = 1'b1; old_val = csr_mepc;      end
      12'h342: begin sel[3] = 1'b1; old_val = csr_mcause;    end
      12'hF11: begin sel[4] = 1'b1; old_val = csr_mvendorid; end
      12'hF12: begin sel[5] = 1'b1; old_val = csr_marchid;   end
      default: begin sel = 6'b0;    old_val = 32'd0;         end
    endcase

    is_csr_op = (op_reg <= OP_CSRRC);
    // CSRRS/CSRRC with a zero mask are pure reads and never write
    wr_req    = (op_reg == OP_CSRRW) || (wdata_reg != 32'd0);
    if (is_csr_op)
      illegal = !(|sel) || ((sel[4] || sel[5]) && wr_req);
    else
      illegal = (op_reg > OP_MRET);
    do_write = is_csr_op && !illegal && wr_req;

    case (op_reg)
      OP_CSRRW: new_val = wdata_reg;
      OP_CSRRS: new_val = old_val | wdata_reg;
      OP_CSRRC: new_val = old_val & ~wdata_reg;
      default:  new_val = old_val;
    endcase

    ecall_mstatus        = csr_mstatus;
    ecall_mstatus[7]     = csr_mstatus[3];
    ecall_mstatus[3]     = 1'b0;
    ecall_mstatus[12:11] = 2'b11;

    mret_mstatus         = csr_mstatus;
    mret_mstatus[3]      = csr_mstatus[7];
    mret_mstatus[7]      = 1'b1;
    mret_mstatus[12:11]  = MSTATUS_RST[12:11];

    rdata_next    = (is_csr_op && !illegal) ? old_val : 32'd0;
    redirect_next = (op_reg == OP_ECALL) || (op_reg == OP_MRET);
    if (op_reg == OP_ECALL)
      npc_next = {csr_mtvec[31:2], 2'b00};
    else if (op_reg == OP_MRET)
      npc_next = csr_mepc;
    else
      npc_next = 32'd0;
  end

  // Write pulses exist only during EXEC; idle data mirrors the CSR file
  always_comb begin
    din_mstatus = csr_mstatus;
    din_mtvec   = csr_mtvec;
    din_mepc    = csr_mepc;
    din_mcause  = csr_mcause;
    wen_mstatus = 1'b0;
    wen_mtvec   = 1'b0;
    wen_mepc    = 1'b0;
    wen_mcause  = 1'b0;
    if (state_reg == EXEC) begin
      if (do_write) begin
        if (sel[0]) begin wen_mstatus = 1'b1; din_mstatus = new_val; end
        if (sel[1]) begin wen_mtvec   = 1'b1; din_mtvec   = new_val; end
        if (sel[2]) begin wen_mepc    = 1'b1; din_mepc    = new_val; end
        if (sel[3]) begin wen_mcause  = 1'b1; din_mcause  = new_val; end
      end else if (op_reg == OP_ECALL) begin
        wen_mstatus = 1'b1;
        din_mstatus = ecall_mstatus;
        wen_mepc    = 1'b1;
        din_mepc    = pc_reg;
        wen_mcause  = 1'b1;
        din_mcause  = ECALL_CAUSE;
      end else if (op_reg == OP_MRET) begin
        wen_mstatus = 1'b1;
        din_mstatus = mret_mstatus;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = EXEC;
      end
      EXEC: state_next = RESP;
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      op_reg        <= 3'd0;
      addr_reg      <= 12'd0;
      wdata_reg     <= 32'd0;
      pc_reg        <= 32'd0;
      resp_rdata    <= 32'd0;
      resp_redirect <= 1'b0;
      resp_npc      <= 32'd0;
      resp_illegal  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && req_valid) begin
        op_reg    <= req_op;
        addr_reg  <= req_csr_addr;
        wdata_reg <= req_wdata;
        pc_reg    <= req_pc;
      end
      if (state_reg == EXEC) begin
        resp_rdata    <= rdata_next;
        resp_redirect <= redirect_next;
        resp_npc      <= npc_next;
        resp_illegal  <= illegal;
      end
    end
  end

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Bench for csr_trap_ctrl: a transaction-level model predicts write pulses and responses each cycle,
// and directed vectors pin the model with hand-computed literals.
module tb_csr_trap_ctrl;

  localparam logic [31:0] ECALL_CAUSE = 32'd11;
  localparam logic [31:0] MS_RST      = 32'h00001800;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [11:0] req_csr_addr = 12'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [31:0] req_pc = 32'd0;
  logic [31:0] csr_mstatus = 32'd0, csr_mtvec = 32'd0, csr_mepc = 32'd0;
  logic [31:0] csr_mcause = 32'd0, csr_mvendorid = 32'h79737978, csr_marchid = 32'd0;
  logic [31:0] din_mstatus, din_mtvec, din_mepc, din_mcause;
  logic        wen_mstatus, wen_mtvec, wen_mepc, wen_mcause;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_redirect;
  logic [31:0] resp_npc;
  logic        resp_illegal;

  csr_trap_ctrl #(.ECALL_CAUSE(ECALL_CAUSE), .MSTATUS_RST(MS_RST)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_csr_addr(req_csr_addr), .req_wdata(req_wdata), .req_pc(req_pc),
    .csr_mstatus(csr_mstatus), .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .csr_mcause(csr_mcause), .csr_mvendorid(csr_mvendorid), .csr_marchid(csr_marchid),
    .din_mstatus(din_mstatus), .din_mtvec(din_mtvec), .din_mepc(din_mepc), .din_mcause(din_mcause),
    .wen_mstatus(wen_mstatus), .wen_mtvec(wen_mtvec), .wen_mepc(wen_mepc), .wen_mcause(wen_mcause),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_redirect(resp_redirect), .resp_npc(resp_npc), .resp_illegal(resp_illegal)
  );

  always #5 clk = ~clk;

  // wen/din index: 0 mstatus, 1 mtvec, 2 mepc, 3 mcause
  typedef struct packed {
    logic [3:0]       wen;
    logic [3:0][31:0] din;
    logic [31:0]      rdata;
    logic             redirect;
    logic [31:0]      npc;
    logic             illegal;
  } exp_t;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [11:0] addr,
                                 input logic [31:0] wd, input logic [31:0] pc,
                                 input logic [5:0][31:0] cur);
    exp_t e;
    int idx;
    logic [31:0] old, nv, ms, rstv;
    e = '0;
    for (int i = 0; i < 4; i++) e.din[i] = cur[i];
    idx = -1;
    case (addr)
      12'h300: idx = 0;
      12'h305: idx = 1;
      12'h341: idx = 2;
      12'h342: idx = 3;
      12'hF11: idx = 4;
      12'hF12: idx = 5;
      default: idx = -1;
    endcase
    rstv = MS_RST;
    if (op <= 3'd2) begin
      if (idx < 0) e.illegal = 1'b1;
      else begin
        old = cur[idx];
        if (op == 3'd0) nv = wd;
        else if (op == 3'd1) nv = old | wd;
        else nv = old & ~wd;
        if (idx >= 4 && (op == 3'd0 || wd != 0)) e.illegal = 1'b1;
        else begin
          e.rdata = old;
          if (op == 3'd0 || wd != 0) begin
            e.wen[idx] = 1'b1;
            e.din[idx] = nv;
          end
        end
      end
    end else if (op == 3'd3) begin
      ms = cur[0];
      ms[7] = cur[0][3];
      ms[3] = 1'b0;
      ms[12:11] = 2'b11;
      e.wen = 4'b1101;
      e.din[0] = ms;
      e.din[2] = pc;
      e.din[3] = ECALL_CAUSE;
      e.redirect = 1'b1;
      e.npc = cur[1] & 32'hFFFFFFFC;
    end else if (op == 3'd4) begin
      ms = cur[0];
      ms[3] = cur[0][7];
      ms[7] = 1'b1;
      ms[12:11] = rstv[12:11];
      e.wen = 4'b0001;
      e.din[0] = ms;
      e.redirect = 1'b1;
      e.npc = cur[2];
    end else begin
      e.illegal = 1'b1;
    end
    return e;
  endfunction

  // Transaction phase as the protocol dictates: 0 idle, 1 execute, 2 responding
  int          phase;
  logic [2:0]  l_op;
  logic [11:0] l_addr;
  logic [31:0] l_wdata, l_pc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= 0;
      l_op <= 3'd0; l_addr <= 12'd0; l_wdata <= 32'd0; l_pc <= 32'd0;
    end else begin
      case (phase)
        0: if (req_valid) begin
             phase <= 1;
             l_op <= req_op; l_addr <= req_csr_addr; l_wdata <= req_wdata; l_pc <= req_pc;
           end
        1: phase <= 2;
        default: if (resp_ready) phase <= 0;
      endcase
    end
  end

  exp_t        e_now, exp_resp;
  logic [3:0]  cap_wen;
  logic [31:0] cap_din [4];
  logic [31:0] cap_rdata, cap_npc;
  logic        cap_redir, cap_ill;

  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_wen", {28'd0, wen_mcause, wen_mepc, wen_mtvec, wen_mstatus}, 32'd0);
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_redirect", {31'd0, resp_redirect}, 32'd0);
      chk("rst_npc", resp_npc, 32'd0);
      chk("rst_illegal", {31'd0, resp_illegal}, 32'd0);
    end else begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, phase == 0});
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, phase == 2});
      if (phase == 1) begin
        e_now = model(l_op, l_addr, l_wdata, l_pc,
                      {csr_marchid, csr_mvendorid, csr_mcause, csr_mepc, csr_mtvec, csr_mstatus});
        exp_resp = e_now;
        chk("wen", {28'd0, wen_mcause, wen_mepc, wen_mtvec, wen_mstatus}, {28'd0, e_now.wen});
        chk("din_mstatus", din_mstatus, e_now.din[0]);
        chk("din_mtvec", din_mtvec, e_now.din[1]);
        chk("din_mepc", din_mepc, e_now.din[2]);
        chk("din_mcause", din_mcause, e_now.din[3]);
        cap_wen = {wen_mcause, wen_mepc, wen_mtvec, wen_mstatus};
        cap_din[0] = din_mstatus; cap_din[1] = din_mtvec;
        cap_din[2] = din_mepc;    cap_din[3] = din_mcause;
      end else begin
        chk("wen_idle", {28'd0, wen_mcause, wen_mepc, wen_mtvec, wen_mstatus}, 32'd0);
      end
      if (phase == 2) begin
        chk("resp_rdata", resp_rdata, exp_resp.rdata);
        chk("resp_redirect", {31'd0, resp_redirect}, {31'd0, exp_resp.redirect});
        chk("resp_npc", resp_npc, exp_resp.npc);
        chk("resp_illegal", {31'd0, resp_illegal}, {31'd0, exp_resp.illegal});
        cap_rdata = resp_rdata; cap_npc = resp_npc;
        cap_redir = resp_redirect; cap_ill = resp_illegal;
      end
    end
  end

  // Called at #1 after a rising edge; returns at #1 after the response handshake edge
  task automatic txn(input logic [2:0] op, input logic [11:0] a, input logic [31:0] wd,
                     input logic [31:0] pc, input int hold);
    int n;
    n = 0;
    while (phase != 0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("idle_timeout", {31'd0, phase == 0}, 32'd1);
    req_valid = 1'b1; req_op = op; req_csr_addr = a; req_wdata = wd; req_pc = pc;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    repeat (hold) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    $display("txn op=%0d addr=%h wdata=%h pc=%h -> wen=%b rdata=%h redir=%0d npc=%h ill=%0d",
             op, a, wd, pc, cap_wen, cap_rdata, cap_redir, cap_npc, cap_ill);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    csr_mtvec = 32'd0;
    txn(3'd0, 12'h305, 32'h80000100, 32'h0, 0);
    chk("t1_wen", {28'd0, cap_wen}, 32'h2);
    chk("t1_din_mtvec", cap_din[1], 32'h80000100);
    chk("t1_rdata", cap_rdata, 32'h0);
    chk("t1_redir_ill", {30'd0, cap_redir, cap_ill}, 32'd0);

    csr_mstatus = 32'h00001808; csr_mtvec = 32'h80000103;
    txn(3'd3, 12'h0, 32'h0, 32'h80000040, 0);
    chk("ecall_wen", {28'd0, cap_wen}, 32'hD);
    chk("ecall_mstatus", cap_din[0], 32'h00001880);
    chk("ecall_mepc", cap_din[2], 32'h80000040);
    chk("ecall_mcause", cap_din[3], 32'd11);
    chk("ecall_npc", cap_npc, 32'h80000100);
    chk("ecall_redir", {31'd0, cap_redir}, 32'd1);

    csr_mstatus = 32'h00001880; csr_mepc = 32'h80000044;
    txn(3'd4, 12'h0, 32'h0, 32'h0, 0);
    chk("mret_wen", {28'd0, cap_wen}, 32'h1);
    chk("mret_mstatus", cap_din[0], 32'h00001888);
    chk("mret_npc", cap_npc, 32'h80000044);

    txn(3'd1, 12'hF11, 32'h0, 32'h0, 0);
    chk("rs_ro_rdata", cap_rdata, 32'h79737978);
    chk("rs_ro_wen_ill", {27'd0, cap_wen, cap_ill}, 32'd0);

    csr_marchid = 32'h0000002A;
    txn(3'd0, 12'hF12, 32'h1, 32'h0, 0);
    chk("rw_ro_ill", {31'd0, cap_ill}, 32'd1);
    chk("rw_ro_wen_rdata", {cap_wen, cap_rdata[27:0]}, 32'd0);

    txn(3'd2, 12'h7C0, 32'h5, 32'h0, 0);
    chk("rc_badaddr_ill", {31'd0, cap_ill}, 32'd1);

    txn(3'd5, 12'h300, 32'hFFFF, 32'h0, 0);
    chk("op5_ill_redir", {30'd0, cap_ill, cap_redir}, 32'h2);

    csr_mstatus = 32'h00001800;
    txn(3'd1, 12'h300, 32'h8, 32'h0, 0);
    chk("rs_mstatus_din", cap_din[0], 32'h00001808);
    chk("rs_mstatus_rdata", cap_rdata, 32'h00001800);

    csr_mepc = 32'h80000047;
    txn(3'd2, 12'h341, 32'h3, 32'h0, 0);
    chk("rc_mepc_wen", {28'd0, cap_wen}, 32'h4);
    chk("rc_mepc_din", cap_din[2], 32'h80000044);

    csr_mcause = 32'h8000000B;
    txn(3'd1, 12'h342, 32'h0, 32'h0, 0);
    chk("rs_zero_wen", {28'd0, cap_wen}, 32'd0);
    chk("rs_zero_rdata", cap_rdata, 32'h8000000B);

    // Stalled consumer, then an immediate follow-on request
    txn(3'd0, 12'h342, 32'h12345678, 32'h0, 5);
    chk("hold_rdata", cap_rdata, 32'h8000000B);
    txn(3'd3, 12'h0, 32'h0, 32'h80000200, 0);
    chk("b2b_npc", cap_npc, 32'h80000100);

    // Reset asserted while a write is in EXEC
    req_valid = 1'b1; req_op = 3'd0; req_csr_addr = 12'h305; req_wdata = 32'hDEADBEEC;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("exec_wen_before_rst", {31'd0, wen_mtvec}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("wen_after_rst", {28'd0, wen_mcause, wen_mepc, wen_mtvec, wen_mstatus}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("post_rst_no_resp", {31'd0, resp_valid}, 32'd0);

    txn(3'd0, 12'h305, 32'h00000040, 32'h0, 0);
    chk("post_rst_txn", cap_din[1], 32'h00000040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/csr_trap_ctrl.md
Name: csr_trap_ctrl

Overview:
Control stage directly upstream of the machine-mode CSR register file. It executes CSR instructions (CSRRW/CSRRS/CSRRC) and the trap instructions ECALL and MRET. It produces the per-CSR write data and write-enable pulses that the CSR file consumes, plus the read data and PC redirect returned to the pipeline. The pipeline side uses valid/ready on both the request and the response, through a 3-state FSM.

Parameters:
ECALL_CAUSE, 32'd11, value written to mcause on ECALL (environment call from M-mode).
MSTATUS_RST, 32'h00001800, MPP=2'b11 value restored into the MPP field on MRET.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, asynchronous, active-low (0 = reset).
req_valid  input  1  request valid.
req_ready  output  1  block can accept a request.
req_op  input  3  0=CSRRW, 1=CSRRS, 2=CSRRC, 3=ECALL, 4=MRET; 5-7 illegal.
req_csr_addr  input  12  CSR address (CSR ops only).
req_wdata  input  32  rs1 value (CSR ops only).
req_pc  input  32  PC of the instruction.
csr_mstatus, csr_mtvec, csr_mepc, csr_mcause, csr_mvendorid, csr_marchid  input  32 each  current CSR values from the CSR file.
din_mstatus, din_mtvec, din_mepc, din_mcause  output  32 each  write data to the CSR file.
wen_mstatus, wen_mtvec, wen_mepc, wen_mcause  output  1 each  write-enable pulses to the CSR file.
resp_valid  output  1  response valid.
resp_ready  input  1  consumer accepts the response.
resp_rdata  output  32  old CSR value (rd result); 0 for ECALL/MRET/illegal.
resp_redirect  output  1  1 = the pipeline must jump to resp_npc.
resp_npc  output  32  redirect target.
resp_illegal  output  1  illegal instruction or illegal CSR access; no CSR was written.

Behaviour:
- Reset state: FSM=IDLE; all latched request fields 0; resp_valid, resp_rdata, resp_redirect, resp_npc, resp_illegal and all wen_* = 0. Reset asserted mid-operation aborts the operation: no wen pulse after reset asserts and no response is issued.
- FSM states:
  - IDLE: req_ready=1. On req_valid && req_ready, latch op/addr/wdata/pc and go to EXEC.
  - EXEC: exactly one cycle; req_ready=0. wen_* are combinational and asserted only in EXEC. resp_* are registered at the end of EXEC. Next state is RESP.
  - RESP: resp_valid=1; all resp_* held stable until resp_valid && resp_ready, then go to IDLE. There is no request bypass: a new request is accepted only in IDLE, so the minimum issue interval is 3 cycles.
- Address map: 0x300 mstatus, 0x305 mtvec, 0x341 mepc, 0x342 mcause (all RW); 0xF11 mvendorid, 0xF12 marchid (RO). Any other address is illegal.
- CSR ops, with old = the addressed csr_* value sampled in EXEC:
  - CSRRW new = wdata.
  - CSRRS new = old | wdata.
  - CSRRC new = old & ~wdata.
  - resp_rdata = old; resp_redirect = 0.
  - Write suppression: for CSRRS/CSRRC with wdata==0 no wen is asserted.
  - RO address: CSRRW is illegal; CSRRS/CSRRC with wdata != 0 is illegal. CSRRS/CSRRC with wdata==0 is legal and returns the value.
  - Only the addressed CSR's wen is pulsed.
- ECALL:
  - Write mepc = pc and mcause = ECALL_CAUSE.
  - Write mstatus: MPIE[7] <= MIE[3], MIE[3] <= 0, MPP[12:11] <= 2'b11, other bits unchanged.
  - wen_mstatus, wen_mepc and wen_mcause pulse in the same cycle.
  - resp_redirect=1, resp_npc = csr_mtvec & 32'hFFFFFFFC (direct mode only).
- MRET:
  - Write mstatus: MIE[3] <= MPIE[7], MPIE[7] <= 1, MPP <= MSTATUS_RST[12:11]; other bits unchanged.
  - resp_redirect=1, resp_npc = csr_mepc.
- Illegal op (5-7) or illegal access: no wen asserted; resp_illegal=1; resp_redirect=0; resp_rdata=0.
- All din_* are don't-care when the corresponding wen is 0; drive them to the current csr_* value.
- All arithmetic is 32-bit bitwise; there is no overflow case.

Test Plan:
- CSRRW 0x305, wdata=0x80000100, mtvec=0 -> handshake accepted at cycle 0; wen_mtvec=1 with din_mtvec=0x80000100 at cycle 1 only; resp_valid at cycle 2 with resp_rdata=0, redirect=0, illegal=0.
- ECALL pc=0x80000040, mstatus=0x00001808, mtvec=0x80000103 -> single EXEC cycle with din_mepc=0x80000040, din_mcause=11 and din_mstatus=0x00001880; response has redirect=1, npc=0x80000100.
- MRET with mstatus=0x00001880, mepc=0x80000044 -> din_mstatus=0x00001888, wen_mstatus=1; response has redirect=1, npc=0x80000044.
- CSRRS 0xF11 wdata=0 -> rdata=0x79737978, no wen. CSRRW 0xF12 -> illegal=1, no wen. CSRRC 0x7C0 -> illegal=1.
- Hold resp_ready=0 for 5 cycles -> resp_* stable and req_ready=0 throughout; on resp_ready=1 the FSM returns to IDLE and a back-to-back request is accepted the next cycle.
- Assert rst low during EXEC of a CSRRW -> wen_* drop immediately; no response is produced; after release the FSM is in IDLE with req_ready=1.
